// File: rtl/toeplitz_stream_if.sv
// Handshake bundle for toeplitz_stream: seed load, raw-bit input stream and result output.
// TOEPLITZ_STUCK_EN adds the out_stuck sideband next to out_data.
interface toeplitz_stream_if #(
   parameter int unsigned N = 256,
   parameter int unsigned L = 128,
   parameter int unsigned W = 8
);
   logic             seed_load;
   logic [N+L-2:0]   seed_data;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [L-1:0]     out_data;
`ifdef TOEPLITZ_STUCK_EN
   logic             out_stuck;
`endif

`ifdef TOEPLITZ_STUCK_EN
   modport master (
      output seed_load, seed_data, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_stuck
   );
   modport slave (
      input  seed_load, seed_data, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_stuck
   );
`else
   modport master (
      output seed_load, seed_data, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  seed_load, seed_data, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
`endif
endinterface

// File: rtl/toeplitz_stream.sv
// Streaming Toeplitz extractor: y = T*x over GF(2) per N-bit block, W bits per beat, one-entry output buffer.
// Optional TOEPLITZ_STUCK_EN adds out_stuck (block was all-zero or all-one).
module toeplitz_stream #(
   parameter int unsigned N = 256,
   parameter int unsigned L = 128,
   parameter int unsigned W = 8
) (
   input  logic              clk,
   input  logic              reset,
   toeplitz_stream_if.slave  bus
);

   localparam int unsigned SW    = N + L - 1;
   localparam int unsigned BEATS = N / W;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic {UNSEEDED, ACCUM} state_t;

   state_t          state;
   logic [SW-1:0]   seed_q;
   logic [SW-1:0]   win_q;
   logic [L-1:0]    acc_q;
   logic [L-1:0]    acc_nxt;
   logic [CW-1:0]   beat_q;
   logic [L-1:0]    out_q;
   logic            out_valid_q;
   logic            last_beat_c;
   logic            in_ready_c;
   logic            beat_fire_c;

   assign last_beat_c = (beat_q == LAST_BEAT);
   assign in_ready_c  = (state == ACCUM) && !bus.seed_load && !(last_beat_c && out_valid_q);
   assign beat_fire_c = bus.in_valid && in_ready_c;

   // in_data[W-1] is the earliest bit; bit k selects the window slice starting at W-1-k.
   always_comb begin
      acc_nxt = acc_q;
      for (int unsigned k = 0; k < W; k++) begin
         if (bus.in_data[k]) begin
            acc_nxt = acc_nxt ^ win_q[W-1-k +: L];
         end
      end
   end

   // Seed copy and sliding window; contents are don't-care until the first load.
   always_ff @(posedge clk) begin
      if (bus.seed_load) begin
         seed_q <= bus.seed_data;
         win_q  <= bus.seed_data;
      end else if (beat_fire_c) begin
         win_q  <= last_beat_c ? seed_q : (win_q >> W);
      end
   end

`ifdef TOEPLITZ_STUCK_EN
   logic all0_q;
   logic all1_q;
   logic all0_c;
   logic all1_c;
   logic stuck_q;

   assign all0_c = all0_q && (bus.in_data == '0);
   assign all1_c = all1_q && (&bus.in_data);

   // Running all-zero / all-one flags, restarted with every block and on seed load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         all0_q  <= 1'b1;
         all1_q  <= 1'b1;
         stuck_q <= 1'b0;
      end else if (bus.seed_load) begin
         all0_q  <= 1'b1;
         all1_q  <= 1'b1;
      end else if (beat_fire_c) begin
         if (last_beat_c) begin
            all0_q  <= 1'b1;
            all1_q  <= 1'b1;
            stuck_q <= all0_c || all1_c;
         end else begin
            all0_q  <= all0_c;
            all1_q  <= all1_c;
         end
      end
   end

   assign bus.out_stuck = stuck_q;
`endif

   // Control FSM, accumulator, beat counter and output buffer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= UNSEEDED;
         acc_q       <= '0;
         beat_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (bus.seed_load) begin
            state  <= ACCUM;
            acc_q  <= '0;
            beat_q <= '0;
         end else if (beat_fire_c) begin
            if (last_beat_c) begin
               acc_q       <= '0;
               beat_q      <= '0;
               out_q       <= acc_nxt;
               out_valid_q <= 1'b1;
            end else begin
               acc_q  <= acc_nxt;
               beat_q <= beat_q + CW'(1);
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_q;

endmodule

// File: tb/tb_toeplitz_stream.sv
// Bench for toeplitz_stream: directed N=8/L=4/W=2 steps plus N=256/L=128 blocks at W=1,8,64.
// Results are scoreboarded against expected values pushed when each block is driven.
module tb_toeplitz_stream;

   localparam int unsigned SN  = 8;
   localparam int unsigned SL  = 4;
   localparam int unsigned SW  = 2;
   localparam int unsigned SSW = SN + SL - 1;
   localparam int unsigned BN  = 256;
   localparam int unsigned BL  = 128;
   localparam int unsigned BSW = BN + BL - 1;
   localparam logic [BSW-1:0] BSEED = {64'hC3A5F00F96E1D2B4, 64'h13579BDF2468ACE0, 64'h0F1E2D3C4B5A6978,
                                       64'hFEDCBA9876543210, 64'h5555AAAA3333CCCC, 63'h123456789ABCDEF1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic breset;
   int   checks   = 0;
   int   failures = 0;
   logic ready_force;
   logic ready_val;
   logic ready_rnd;
   logic [SL-1:0] sq[$];
   logic          sstq[$];
   logic [BN-1:0] bx [4] = '{ {8{32'hDEADBEEF}},
                              256'h0123456789ABCDEFFEDCBA98765432100F1E2D3C4B5A69788796A5B4C3D2E1F0,
                              {BN{1'b1}},
                              {4{64'h8000000000000001}} };

   toeplitz_stream_if #(.N(SN), .L(SL), .W(SW)) sif ();
   toeplitz_stream #(.N(SN), .L(SL), .W(SW)) dut (.clk(clk), .reset(reset), .bus(sif.slave));

   assign sif.out_ready = ready_force ? ready_val : ready_rnd;

   initial begin
      ready_rnd = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ready_rnd = 1'($urandom_range(0, 1));
      end
   end

   // Reference: T[i][j] = s[i+n-1-j], y[i] = XOR_j T[i][j] & x[j].
   function automatic logic [BL-1:0] tmodel(input int n, input int l, input logic [BSW-1:0] s,
                                            input logic [BN-1:0] x);
      logic [BL-1:0] y;
      y = '0;
      for (int i = 0; i < l; i++)
         for (int j = 0; j < n; j++)
            y[i] = y[i] ^ (s[i+n-1-j] & x[j]);
      return y;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_seed(input logic [SSW-1:0] s);
      sif.seed_load = 1'b1;
      sif.seed_data = s;
      @(negedge clk);
      check("seed_cycle_in_ready", 256'(sif.in_ready), 256'(0));
      cyc();
      sif.seed_load = 1'b0;
   endtask

   task automatic expect_small(input logic [SL-1:0] y, input logic [SN-1:0] x);
      sq.push_back(y);
      sstq.push_back((x == '0) || (x == '1));
   endtask

   task automatic send_beats(input logic [SN-1:0] x, input int first, input int cnt, input bit gaps);
      logic ok;
      for (int b = first; b < first + cnt; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               sif.in_valid = 1'b0;
               cyc();
            end
         end
         sif.in_valid = 1'b1;
         sif.in_data  = x[SN-1-b*SW -: SW];
         ok = 1'b0;
         for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = sif.in_ready;
            cyc();
         end
         check("beat_accept", 256'(ok), 256'(1));
      end
      sif.in_valid = 1'b0;
   endtask

   task automatic drain();
      ready_val = 1'b1;
      for (int t = 0; t < 100 && sq.size() > 0; t++) cyc();
      check("drain_empty", 256'(sq.size()), 256'(0));
      @(negedge clk);
      check("drain_out_valid_low", 256'(sif.out_valid), 256'(0));
      cyc();
   endtask

   // Small-DUT scoreboard: compare on every output handshake.
   initial forever begin
      @(negedge clk);
      if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
         check("out_expected", 256'(sq.size() > 0), 256'(1));
         if (sq.size() > 0) begin
            check("out_data", 256'(sif.out_data), 256'(sq.pop_front()));
`ifdef TOEPLITZ_STUCK_EN
            check("out_stuck", 256'(sif.out_stuck), 256'(sstq.pop_front()));
`else
            void'(sstq.pop_front());
`endif
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : gb
      localparam int unsigned WW = (g == 0) ? 1 : ((g == 1) ? 8 : 64);
      localparam int unsigned BB = BN / WW;
      logic done = 1'b0;
      logic [BL-1:0] bq[$];
      logic          bsq[$];

      toeplitz_stream_if #(.N(BN), .L(BL), .W(WW)) bif ();
      toeplitz_stream #(.N(BN), .L(BL), .W(WW)) bdut (.clk(clk), .reset(breset), .bus(bif.slave));

      initial begin
         bif.out_ready = 1'b0;
         forever begin
            @(posedge clk);
            #1;
            bif.out_ready = 1'($urandom_range(0, 1));
         end
      end

      initial forever begin
         @(negedge clk);
         if (bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
            check($sformatf("big_w%0d_expected", WW), 256'(bq.size() > 0), 256'(1));
            if (bq.size() > 0) begin
               check($sformatf("big_w%0d_y", WW), 256'(bif.out_data), 256'(bq.pop_front()));
`ifdef TOEPLITZ_STUCK_EN
               check($sformatf("big_w%0d_stuck", WW), 256'(bif.out_stuck), 256'(bsq.pop_front()));
`else
               void'(bsq.pop_front());
`endif
            end
         end
      end

      initial begin
         logic ok;
         bif.seed_load = 1'b0;
         bif.seed_data = '0;
         bif.in_valid  = 1'b0;
         bif.in_data   = '0;
         wait (breset === 1'b1);
         @(posedge clk);
         #1;
         bif.seed_load = 1'b1;
         bif.seed_data = BSEED;
         @(posedge clk);
         #1;
         bif.seed_load = 1'b0;
         for (int v = 0; v < 4; v++) begin
            bq.push_back(tmodel(BN, BL, BSEED, bx[v]));
            bsq.push_back((bx[v] == '0) || (bx[v] == '1));
            for (int b = 0; b < BB; b++) begin
               repeat ($urandom_range(0, 2)) begin
                  bif.in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
               bif.in_valid = 1'b1;
               bif.in_data  = bx[v][BN-1-b*WW -: WW];
               ok = 1'b0;
               for (int t = 0; t < 2000 && !ok; t++) begin
                  @(negedge clk);
                  ok = bif.in_ready;
                  @(posedge clk);
                  #1;
               end
               if (!ok) check($sformatf("big_w%0d_beat_timeout", WW), 256'(ok), 256'(1));
            end
            bif.in_valid = 1'b0;
         end
         for (int t = 0; t < 5000 && bq.size() > 0; t++) begin
            @(posedge clk);
            #1;
         end
         done = 1'b1;
      end
   end

   initial begin
      reset         = 1'b0;
      breset        = 1'b0;
      ready_force   = 1'b1;
      ready_val     = 1'b1;
      sif.seed_load = 1'b0;
      sif.seed_data = '0;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      repeat (2) cyc();
      @(negedge clk);
      check("reset_in_ready", 256'(sif.in_ready), 256'(0));
      check("reset_out_valid", 256'(sif.out_valid), 256'(0));
      check("reset_out_data", 256'(sif.out_data), 256'(0));
      cyc();
      reset  = 1'b1;
      breset = 1'b1;
      sif.in_valid = 1'b1;
      sif.in_data  = 2'b11;
      @(negedge clk);
      check("unseeded_in_ready", 256'(sif.in_ready), 256'(0));
      cyc();
      sif.in_valid = 1'b0;

      // All-ones seed: every output bit is the block parity.
      load_seed(11'h7FF);
      expect_small(4'h0, 8'hA5);
      send_beats(8'hA5, 0, 4, 1'b1);
      expect_small(4'hF, 8'h01);
      send_beats(8'h01, 0, 4, 1'b1);
      drain();

      // Single-tap seeds and one-cycle output latency.
      load_seed(11'h080);
      ready_val = 1'b0;
      expect_small(4'h5, 8'hA5);
      send_beats(8'hA5, 0, 3, 1'b0);
      sif.in_valid = 1'b1;
      sif.in_data  = 2'b01;
      @(negedge clk);
      check("lat_last_beat_ready", 256'(sif.in_ready), 256'(1));
      check("lat_before_valid", 256'(sif.out_valid), 256'(0));
      cyc();
      sif.in_valid = 1'b0;
      @(negedge clk);
      check("lat_valid_next_cycle", 256'(sif.out_valid), 256'(1));
      check("lat_data", 256'(sif.out_data), 256'(4'h5));
      cyc();
      drain();
      load_seed(11'h001);
      expect_small(4'h1, 8'h80);
      send_beats(8'h80, 0, 4, 1'b0);
      drain();

      // Backpressure: second block's last beat stalls until the buffer drains.
      load_seed(11'h080);
      ready_val = 1'b0;
      expect_small(4'hF, 8'h0F);
      send_beats(8'h0F, 0, 4, 1'b0);
      expect_small(4'h3, 8'hF3);
      send_beats(8'hF3, 0, 3, 1'b0);
      sif.in_valid = 1'b1;
      sif.in_data  = 2'b11;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_in_ready", 256'(sif.in_ready), 256'(0));
         check("bp_out_valid", 256'(sif.out_valid), 256'(1));
         check("bp_out_data_held", 256'(sif.out_data), 256'(4'hF));
         cyc();
      end
      ready_val = 1'b1;
      @(negedge clk);
      check("bp_in_ready_at_drain", 256'(sif.in_ready), 256'(0));
      cyc();
      ready_val = 1'b0;
      send_beats(8'hF3, 3, 1, 1'b0);
      @(negedge clk);
      check("bp_second_valid", 256'(sif.out_valid), 256'(1));
      check("bp_second_data", 256'(sif.out_data), 256'(4'h3));
      cyc();
      drain();

      // Mid-block seed load discards the partial block.
      load_seed(11'h7FF);
      send_beats(8'h3C, 0, 2, 1'b0);
      load_seed(11'h080);
      @(negedge clk);
      check("partial_no_valid", 256'(sif.out_valid), 256'(0));
      cyc();
      expect_small(4'h6, 8'hC6);
      send_beats(8'hC6, 0, 4, 1'b1);
      drain();

      // Reset with a result pending and a block in flight.
      ready_val = 1'b0;
      expect_small(4'hA, 8'h5A);
      send_beats(8'h5A, 0, 4, 1'b0);
      send_beats(8'h77, 0, 2, 1'b0);
      @(negedge clk);
      check("pre_reset_valid", 256'(sif.out_valid), 256'(1));
      cyc();
      reset = 1'b0;
      sq.delete();
      sstq.delete();
      cyc();
      reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 256'(sif.in_ready), 256'(0));
      check("rst_out_valid", 256'(sif.out_valid), 256'(0));
      check("rst_out_data", 256'(sif.out_data), 256'(0));
      cyc();
      sif.in_valid = 1'b1;
      sif.in_data  = 2'b11;
      repeat (2) begin
         @(negedge clk);
         check("post_reset_in_ready", 256'(sif.in_ready), 256'(0));
         cyc();
      end
      ready_val = 1'b1;
      load_seed(11'h0A5);
      expect_small(SL'(tmodel(SN, SL, BSW'(11'h0A5), BN'(8'h96))), 8'h96);
      send_beats(8'h96, 0, 4, 1'b0);
      drain();

      for (int t = 0; t < 60000 && !(gb[0].done && gb[1].done && gb[2].done); t++) cyc();
      check("big_done", 256'({gb[0].done, gb[1].done, gb[2].done}), 256'(3'b111));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
